// File: rtl/dispatch_credit_ctrl_if.sv
// rtl/dispatch_credit_ctrl_if.sv - IFetcher-to-issue handshake bundle for dispatch_credit_ctrl
interface dispatch_credit_ctrl_if;
  logic       if_valid;
  logic [6:0] if_opcode;
  logic       if_ready;
  logic       issue_fire;
  logic       illegal_op;

  modport master (
    output if_valid, if_opcode,
    input  if_ready, issue_fire, illegal_op
  );

  modport slave (
    input  if_valid, if_opcode,
    output if_ready, issue_fire, illegal_op
  );
endinterface

// File: rtl/dispatch_credit_ctrl.sv
// rtl/dispatch_credit_ctrl.sv - ROB/RS/LSB credit admission control with flush recovery
module dispatch_credit_ctrl #(
  parameter int ROB_DEPTH    = 16,
  parameter int RS_DEPTH     = 16,
  parameter int LSB_DEPTH    = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CW           = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  dispatch_credit_ctrl_if.slave fe,
  input  logic                  flush,
  input  logic                  rob_free,
  input  logic                  rs_free,
  input  logic                  lsb_free,
  output logic [CW-1:0]         rob_credits,
  output logic [CW-1:0]         rs_credits,
  output logic [CW-1:0]         lsb_credits,
  output logic                  busy_flush,
  output logic                  credit_err
);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] ROB_FULL   = CW'(ROB_DEPTH);
  localparam logic [CW-1:0] RS_FULL    = CW'(RS_DEPTH);
  localparam logic [CW-1:0] LSB_FULL   = CW'(LSB_DEPTH);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t        state, state_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [CW-1:0] rob_n, rs_n, lsb_n;
  logic [CW-1:0] rob_upd, rs_upd, lsb_upd;
  logic          rob_ovf, rs_ovf, lsb_ovf;
  logic          err_n;
  logic          need_rob, need_rs, need_lsb, legal;
  logic          run_ok, credits_ok;

  always_comb begin
    need_rob = 1'b0;
    need_rs  = 1'b0;
    need_lsb = 1'b0;
    legal    = 1'b1;
    case (fe.if_opcode)
      7'b0110111, 7'b0010111, 7'b1101111: need_rob = 1'b1;
      7'b1100111, 7'b1100011, 7'b0010011, 7'b0110011: begin
        need_rob = 1'b1;
        need_rs  = 1'b1;
      end
      7'b0000011, 7'b0100011: begin
        need_rob = 1'b1;
        need_rs  = 1'b1;
        need_lsb = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Admission looks only at registered credits, so issue_fire never loops back into if_ready.
  assign run_ok     = !rst && rdy && (state == S_RUN);
  assign credits_ok = (!need_rob || rob_credits != '0) &&
                      (!need_rs  || rs_credits  != '0) &&
                      (!need_lsb || lsb_credits != '0);

  assign fe.if_ready   = run_ok && credits_ok;
  assign fe.issue_fire = fe.if_valid && fe.if_ready && legal;
  assign fe.illegal_op = fe.if_valid && fe.if_ready && !legal;
  assign busy_flush    = (state == S_FLUSH);

  // Returns {overflow, next}; a release into a full counter saturates and flags overflow.
  function automatic logic [CW:0] credit_next(input logic [CW-1:0] cnt, input logic rel,
                                              input logic res, input logic [CW-1:0] full);
    if (rel && !res)
      return (cnt == full) ? {1'b1, cnt} : {1'b0, cnt + 1'b1};
    else if (res && !rel)
      return {1'b0, cnt - 1'b1};
    return {1'b0, cnt};
  endfunction

  always_comb begin
    {rob_ovf, rob_upd} = credit_next(rob_credits, rob_free, fe.issue_fire && need_rob, ROB_FULL);
    {rs_ovf,  rs_upd}  = credit_next(rs_credits,  rs_free,  fe.issue_fire && need_rs,  RS_FULL);
    {lsb_ovf, lsb_upd} = credit_next(lsb_credits, lsb_free, fe.issue_fire && need_lsb, LSB_FULL);
  end

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    rob_n   = rob_credits;
    rs_n    = rs_credits;
    lsb_n   = lsb_credits;
    err_n   = credit_err;
    if (rdy) begin
      case (state)
        S_RUN: begin
          if (flush) begin
            state_n = S_FLUSH;
            fcnt_n  = FLUSH_LOAD;
          end else begin
            rob_n = rob_upd;
            rs_n  = rs_upd;
            lsb_n = lsb_upd;
            err_n = credit_err | rob_ovf | rs_ovf | lsb_ovf;
          end
        end
        S_FLUSH: begin
          if (flush)
            fcnt_n = FLUSH_LOAD;
          else if (fcnt == '0)
            state_n = S_RUN;
          else
            fcnt_n = fcnt - 1'b1;
        end
      endcase
      // A flush discards any same-cycle fire and any in-flight frees.
      if (flush || state == S_FLUSH) begin
        rob_n = ROB_FULL;
        rs_n  = RS_FULL;
        lsb_n = LSB_FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      fcnt        <= '0;
      rob_credits <= ROB_FULL;
      rs_credits  <= RS_FULL;
      lsb_credits <= LSB_FULL;
      credit_err  <= 1'b0;
    end else begin
      state       <= state_n;
      fcnt        <= fcnt_n;
      rob_credits <= rob_n;
      rs_credits  <= rs_n;
      lsb_credits <= lsb_n;
      credit_err  <= err_n;
    end
  end
endmodule
